ps2_time_entry_ctrl: RTL and testbench

- Sequences the ps2_keyboard scan-code FIFO and converts keystrokes into time-set and alarm-set commands for the clock core.
- Pops bytes with the nextdata_n handshake and strips break and extended codes.
- Runs a time/alarm entry state machine that collects six BCD digits (HHMMSS), range-checks them, and issues one-cycle load pulses.
- Sits between ps2_keyboard and the clock/alarm registers in the top level.

---
 rtl/ps2_time_entry_ctrl_if.sv | 9 +
 rtl/ps2_time_entry_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_ps2_time_entry_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_time_entry_ctrl_if.sv
// Scan-code FIFO handshake between ps2_keyboard (slave) and the time-entry controller (master).
interface ps2_time_entry_ctrl_if;
  logic [7:0] kb_data;
  logic       kb_ready;
  logic       nextdata_n;

  modport master (input kb_data, input kb_ready, output nextdata_n);
  modport slave  (output kb_data, output kb_ready, input nextdata_n);
endinterface

// File: rtl/ps2_time_entry_ctrl.sv
// Pops PS/2 scan codes, filters break/extended prefixes and runs the
// time/alarm HHMMSS entry state machine that issues load or error pulses.
module ps2_time_entry_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 500000000,
  parameter int unsigned TO_W           = 29
) (
  input  logic                          CLK_50,
  input  logic                          clrn,
  ps2_time_entry_ctrl_if.master         kb,
  output logic                          set_en,
  output logic                          alarm_en,
  output logic [23:0]                   entry_bcd,
  output logic [2:0]                    digit_cnt,
  output logic                          load_time,
  output logic                          load_alarm,
  output logic                          entry_err
);

  localparam int unsigned CODE_W = 8;
  localparam int unsigned BCD_W  = 24;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned DIG_W  = 4;

  localparam logic [CODE_W-1:0] CODE_EXT   = 8'hE0;
  localparam logic [CODE_W-1:0] CODE_BREAK = 8'hF0;
  localparam logic [CODE_W-1:0] CODE_T     = 8'h2C;
  localparam logic [CODE_W-1:0] CODE_A     = 8'h1C;
  localparam logic [CODE_W-1:0] CODE_ENTER = 8'h5A;
  localparam logic [CODE_W-1:0] CODE_ESC   = 8'h76;
  localparam logic [CODE_W-1:0] CODE_BKSP  = 8'h66;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(6);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TIME  = 2'd1,
    S_ALARM = 2'd2,
    S_CHECK = 2'd3
  } state_t;

  state_t              state_q, state_nx;
  logic                pop_q, pop_nx;
  logic [CODE_W-1:0]   code_q, code_nx;
  logic                break_q, break_nx;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_nx;
  logic                nextdata_nx;
  logic                set_en_nx, alarm_en_nx;
  logic [BCD_W-1:0]    bcd_nx;
  logic [CNT_W-1:0]    cnt_nx;
  logic                load_time_nx, load_alarm_nx, entry_err_nx;

  logic                make_c;
  logic                is_digit_c;
  logic [DIG_W-1:0]    digit_c;
  logic                entry_ok_c;

  // Fetch: pop_q marks the cycle in which nextdata_n is low and code_q is decoded.
  always_comb begin
    pop_nx      = !pop_q && kb.kb_ready;
    nextdata_nx = !pop_nx;
    code_nx     = pop_nx ? kb.kb_data : code_q;
    break_nx    = break_q;
    make_c      = 1'b0;
    if (pop_q) begin
      if (code_q == CODE_BREAK) begin
        break_nx = 1'b1;
      end else if (code_q != CODE_EXT) begin
        if (break_q) break_nx = 1'b0;
        else         make_c   = 1'b1;
      end
    end
  end

  // Set-2 digit decode.
  always_comb begin
    is_digit_c = 1'b1;
    digit_c    = '0;
    case (code_q)
      8'h45:   digit_c = DIG_W'(0);
      8'h16:   digit_c = DIG_W'(1);
      8'h1E:   digit_c = DIG_W'(2);
      8'h26:   digit_c = DIG_W'(3);
      8'h25:   digit_c = DIG_W'(4);
      8'h2E:   digit_c = DIG_W'(5);
      8'h36:   digit_c = DIG_W'(6);
      8'h3D:   digit_c = DIG_W'(7);
      8'h3E:   digit_c = DIG_W'(8);
      8'h46:   digit_c = DIG_W'(9);
      default: is_digit_c = 1'b0;
    endcase
  end

  // Range check of a complete HHMMSS entry.
  always_comb begin
    entry_ok_c = (digit_cnt == FULL_CNT)
              && ((entry_bcd[23:20] < 4'd2) ||
                  ((entry_bcd[23:20] == 4'd2) && (entry_bcd[19:16] <= 4'd3)))
              && (entry_bcd[15:12] <= 4'd5)
              && (entry_bcd[7:4]   <= 4'd5);
  end

  // Main entry FSM: next state and next registered outputs.
  always_comb begin
    state_nx      = state_q;
    set_en_nx     = set_en;
    alarm_en_nx   = alarm_en;
    bcd_nx        = entry_bcd;
    cnt_nx        = digit_cnt;
    to_cnt_nx     = '0;
    load_time_nx  = 1'b0;
    load_alarm_nx = 1'b0;
    entry_err_nx  = 1'b0;
    case (state_q)
      S_IDLE: begin
        set_en_nx   = 1'b0;
        alarm_en_nx = 1'b0;
        if (make_c && (code_q == CODE_T)) begin
          state_nx  = S_TIME;
          set_en_nx = 1'b1;
          bcd_nx    = '0;
          cnt_nx    = '0;
        end else if (make_c && (code_q == CODE_A)) begin
          state_nx    = S_ALARM;
          alarm_en_nx = 1'b1;
          bcd_nx      = '0;
          cnt_nx      = '0;
        end
      end
      S_TIME, S_ALARM: begin
        if (make_c) begin
          if (is_digit_c) begin
            if (digit_cnt < FULL_CNT) begin
              bcd_nx = {entry_bcd[BCD_W-DIG_W-1:0], digit_c};
              cnt_nx = digit_cnt + CNT_W'(1);
            end
          end else if (code_q == CODE_BKSP) begin
            if (digit_cnt != '0) begin
              bcd_nx = {DIG_W'(0), entry_bcd[BCD_W-1:DIG_W]};
              cnt_nx = digit_cnt - CNT_W'(1);
            end
          end else if (code_q == CODE_ENTER) begin
            state_nx = S_CHECK;
          end else if (code_q == CODE_ESC) begin
            state_nx    = S_IDLE;
            set_en_nx   = 1'b0;
            alarm_en_nx = 1'b0;
          end
        end else if (to_cnt_q == TO_LAST) begin
          state_nx     = S_IDLE;
          entry_err_nx = 1'b1;
          set_en_nx    = 1'b0;
          alarm_en_nx  = 1'b0;
        end else begin
          to_cnt_nx = to_cnt_q + TO_W'(1);
        end
      end
      S_CHECK: begin
        // Enables stay up through the pulse cycle; IDLE drops them afterwards.
        state_nx = S_IDLE;
        if (entry_ok_c) begin
          load_time_nx  = set_en;
          load_alarm_nx = alarm_en;
        end else begin
          entry_err_nx = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_50 or negedge clrn) begin
    if (!clrn) begin
      state_q       <= S_IDLE;
      pop_q         <= 1'b0;
      code_q        <= '0;
      break_q       <= 1'b0;
      to_cnt_q      <= '0;
      kb.nextdata_n <= 1'b1;
      set_en        <= 1'b0;
      alarm_en      <= 1'b0;
      entry_bcd     <= '0;
      digit_cnt     <= '0;
      load_time     <= 1'b0;
      load_alarm    <= 1'b0;
      entry_err     <= 1'b0;
    end else begin
      state_q       <= state_nx;
      pop_q         <= pop_nx;
      code_q        <= code_nx;
      break_q       <= break_nx;
      to_cnt_q      <= to_cnt_nx;
      kb.nextdata_n <= nextdata_nx;
      set_en        <= set_en_nx;
      alarm_en      <= alarm_en_nx;
      entry_bcd     <= bcd_nx;
      digit_cnt     <= cnt_nx;
      load_time     <= load_time_nx;
      load_alarm    <= load_alarm_nx;
      entry_err     <= entry_err_nx;
    end
  end

endmodule

// File: tb/tb_ps2_time_entry_ctrl.sv
// Scoreboard bench for ps2_time_entry_ctrl: a FIFO model feeds scan codes,
// expected events are queued by the stimulus and popped by an output monitor.
`timescale 1ns/1ps
module tb_ps2_time_entry_ctrl;

  localparam int unsigned TO_CYC = 100;

  localparam logic [1:0] EV_CNT   = 2'd0;
  localparam logic [1:0] EV_LTIME = 2'd1;
  localparam logic [1:0] EV_LALRM = 2'd2;
  localparam logic [1:0] EV_ERR   = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [23:0] bcd;
    logic [2:0]  cnt;
    logic        se;
    logic        ae;
  } ev_t;

  logic        CLK_50;
  logic        clrn;
  logic        set_en, alarm_en, load_time, load_alarm, entry_err;
  logic [23:0] entry_bcd;
  logic [2:0]  digit_cnt;

  ps2_time_entry_ctrl_if bus ();

  ps2_time_entry_ctrl #(.TIMEOUT_CYCLES(TO_CYC), .TO_W(29)) dut (
    .CLK_50    (CLK_50),
    .clrn      (clrn),
    .kb        (bus.master),
    .set_en    (set_en),
    .alarm_en  (alarm_en),
    .entry_bcd (entry_bcd),
    .digit_cnt (digit_cnt),
    .load_time (load_time),
    .load_alarm(load_alarm),
    .entry_err (entry_err)
  );

  logic [7:0] fifo[$];
  ev_t        exp_q[$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         cnt_cyc  = 0;
  int         err_cyc  = 0;

  initial begin
    CLK_50 = 1'b0;
    forever #10 CLK_50 = ~CLK_50;
  end

  initial forever begin
    @(posedge CLK_50);
    cyc = cyc + 1;
  end

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    fifo.push_back(b);
  endtask

  task automatic expect_ev(input logic [1:0] kind, input logic [23:0] bcd,
                           input logic [2:0] cnt, input logic se, input logic ae);
    ev_t e;
    e.kind = kind; e.bcd = bcd; e.cnt = cnt; e.se = se; e.ae = ae;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((fifo.size() != 0 || exp_q.size() != 0) && n < 2000) begin
      @(negedge CLK_50);
      n = n + 1;
    end
    if (n >= 2000) begin
      checks   = checks + 1;
      failures = failures + 1;
      $display("FAIL %s drain timeout fifo=%0d pending_events=%0d", name, fifo.size(), exp_q.size());
      fifo.delete();
      exp_q.delete();
    end
    repeat (6) @(negedge CLK_50);
  endtask

  // FIFO model: pops on a low nextdata_n, presents the head byte.
  initial begin
    bus.kb_ready = 1'b0;
    bus.kb_data  = 8'h00;
    forever begin
      @(negedge CLK_50);
      if (clrn && !bus.nextdata_n && fifo.size() > 0) void'(fifo.pop_front());
      bus.kb_ready = (fifo.size() > 0);
      bus.kb_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
    end
  end

  // Monitor: any pulse or digit_cnt change is an event compared to the scoreboard.
  initial begin
    logic [2:0] prev_cnt;
    ev_t        got;
    ev_t        want;
    prev_cnt = 3'd0;
    forever begin
      @(negedge CLK_50);
      if (clrn) begin
        if (load_time || load_alarm || entry_err || digit_cnt != prev_cnt) begin
          got.kind = load_time ? EV_LTIME : load_alarm ? EV_LALRM : entry_err ? EV_ERR : EV_CNT;
          got.bcd  = entry_bcd;
          got.cnt  = digit_cnt;
          got.se   = set_en;
          got.ae   = alarm_en;
          if (got.kind == EV_CNT) cnt_cyc = cyc;
          if (got.kind == EV_ERR) err_cyc = cyc;
          if (exp_q.size() == 0) begin
            checks   = checks + 1;
            failures = failures + 1;
            $display("FAIL unexpected_event actual=0x%0h expected=none", got);
          end else begin
            want = exp_q.pop_front();
            check_val("event", 32'(got), 32'(want));
          end
        end
        prev_cnt = digit_cnt;
      end
    end
  end

  initial begin
    int  first;
    int  same;
    int  dbl;
    logic prev_nd;

    clrn = 1'b0;
    for (int i = 0; i < 24; i++) send(8'h00);
    repeat (3) @(negedge CLK_50);
    check_val("reset_nextdata_n", 32'(bus.nextdata_n), 32'd1);
    check_val("reset_enables", 32'({set_en, alarm_en}), 32'd0);
    check_val("reset_bcd_cnt", 32'({entry_bcd, digit_cnt}), 32'd0);
    check_val("reset_pulses", 32'({load_time, load_alarm, entry_err}), 32'd0);
    check_val("reset_kb_ready", 32'(bus.kb_ready), 32'd1);

    clrn  = 1'b1;
    first = 99;
    for (int i = 1; i <= 4; i++) begin
      @(negedge CLK_50);
      if (first == 99 && !bus.nextdata_n) first = i;
    end
    check_val("first_pop_within_2", 32'(first <= 2), 32'd1);

    // Back-to-back bytes: nextdata_n must alternate every cycle.
    same    = 0;
    dbl     = 0;
    prev_nd = bus.nextdata_n;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK_50);
      if (bus.nextdata_n == prev_nd) same = same + 1;
      if (!bus.nextdata_n && !prev_nd) dbl = dbl + 1;
      prev_nd = bus.nextdata_n;
    end
    check_val("nextdata_toggle", 32'(same), 32'd0);
    check_val("nextdata_double_low", 32'(dbl), 32'd0);
    wait_drain("reset_stream");

    // Time entry 12:30:00 with make/break pairs.
    send(8'h2C);
    send(8'h16); send(8'hF0); send(8'h16);
    send(8'h1E); send(8'hF0); send(8'h1E);
    send(8'h26); send(8'h45); send(8'h45); send(8'h45);
    send(8'h5A);
    expect_ev(EV_CNT,   24'h000001, 3'd1, 1'b1, 1'b0);
    expect_ev(EV_CNT,   24'h000012, 3'd2, 1'b1, 1'b0);
    expect_ev(EV_CNT,   24'h000123, 3'd3, 1'b1, 1'b0);
    expect_ev(EV_CNT,   24'h001230, 3'd4, 1'b1, 1'b0);
    expect_ev(EV_CNT,   24'h012300, 3'd5, 1'b1, 1'b0);
    expect_ev(EV_CNT,   24'h123000, 3'd6, 1'b1, 1'b0);
    expect_ev(EV_LTIME, 24'h123000, 3'd6, 1'b1, 1'b0);
    wait_drain("time_entry");
    check_val("time_entry_set_en_dropped", 32'(set_en), 32'd0);

    // Alarm entry 24:00:00 is out of range.
    send(8'h1C);
    send(8'h1E); send(8'h25); send(8'h45); send(8'h45); send(8'h45); send(8'h45);
    send(8'h5A);
    expect_ev(EV_CNT, 24'h000000, 3'd0, 1'b0, 1'b1);
    expect_ev(EV_CNT, 24'h000002, 3'd1, 1'b0, 1'b1);
    expect_ev(EV_CNT, 24'h000024, 3'd2, 1'b0, 1'b1);
    expect_ev(EV_CNT, 24'h000240, 3'd3, 1'b0, 1'b1);
    expect_ev(EV_CNT, 24'h002400, 3'd4, 1'b0, 1'b1);
    expect_ev(EV_CNT, 24'h024000, 3'd5, 1'b0, 1'b1);
    expect_ev(EV_CNT, 24'h240000, 3'd6, 1'b0, 1'b1);
    expect_ev(EV_ERR, 24'h240000, 3'd6, 1'b0, 1'b1);
    wait_drain("alarm_reject");
    check_val("alarm_reject_idle", 32'({set_en, alarm_en}), 32'd0);

    // Backspace, extended break ignored, then Esc abort.
    send(8'h2C);
    send(8'h16); send(8'h1E); send(8'h26); send(8'h66); send(8'h25);
    send(8'hE0); send(8'hF0); send(8'h66);
    send(8'h76);
    expect_ev(EV_CNT, 24'h000000, 3'd0, 1'b1, 1'b0);
    expect_ev(EV_CNT, 24'h000001, 3'd1, 1'b1, 1'b0);
    expect_ev(EV_CNT, 24'h000012, 3'd2, 1'b1, 1'b0);
    expect_ev(EV_CNT, 24'h000123, 3'd3, 1'b1, 1'b0);
    expect_ev(EV_CNT, 24'h000012, 3'd2, 1'b1, 1'b0);
    expect_ev(EV_CNT, 24'h000124, 3'd3, 1'b1, 1'b0);
    wait_drain("backspace");
    check_val("backspace_final_bcd", 32'(entry_bcd), 32'h000124);
    check_val("esc_clears_set_en", 32'(set_en), 32'd0);

    // Timeout after one digit.
    send(8'h2C);
    send(8'h16);
    expect_ev(EV_CNT, 24'h000000, 3'd0, 1'b1, 1'b0);
    expect_ev(EV_CNT, 24'h000001, 3'd1, 1'b1, 1'b0);
    expect_ev(EV_ERR, 24'h000001, 3'd1, 1'b0, 1'b0);
    wait_drain("timeout");
    check_val("timeout_latency", 32'(err_cyc - cnt_cyc), 32'(TO_CYC));
    check_val("timeout_set_en_low", 32'(set_en), 32'd0);
    check_val("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
